// File: rtl/alu16_arbiter.sv
// Round-robin arbiter that shares one combinational 16-bit ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC waits for the ALU to settle, RESP holds the result.
module alu16_arbiter #(
   parameter int EXEC_CYCLES = 1,
   parameter int DIV_CYCLES  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_op,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_op,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [15:0] rsp0_data,
   output logic        rsp0_err,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [15:0] rsp1_data,
   output logic        rsp1_err,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [4:0]  alu_ctrl,
   input  logic [15:0] alu_result,
   output logic        busy,
   output logic [1:0]  fsm_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // Requesters hold valid and fields until ready; response regs hold until rspN_ready.

   localparam int MAXC = (DIV_CYCLES > EXEC_CYCLES) ? DIV_CYCLES : EXEC_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t          state;
   logic            last;
   logic            id;
   logic [CW-1:0]   cnt;
   logic            grant;
   logic            accept;
   logic [4:0]      sel_op;
   logic [15:0]     sel_a;
   logic [15:0]     sel_b;
   logic [15:0]     cap_data;
   logic            cap_err;
   logic            rsp_take;

   function automatic logic is_divmod(input logic [4:0] op);
      return (op == 5'b00111) || (op == 5'b01001);
   endfunction

   function automatic logic is_illegal(input logic [4:0] op);
      return (op == 5'b00110) || (op == 5'b01011) || (op >= 5'b10010);
   endfunction

   // A lone requester always wins; on a tie the port not served last goes first.
   always_comb begin
      grant = req1_valid;
      if (req0_valid && req1_valid) grant = ~last;
   end

   assign accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
   assign req0_ready = accept && !grant;
   assign req1_ready = accept && grant;

   assign sel_op = grant ? req1_op : req0_op;
   assign sel_a  = grant ? req1_a  : req0_a;
   assign sel_b  = grant ? req1_b  : req0_b;

   // Error cases replace whatever the ALU produced.
   always_comb begin
      cap_data = alu_result;
      cap_err  = 1'b0;
      if (is_illegal(alu_ctrl) || (is_divmod(alu_ctrl) && alu_b == 16'd0)) begin
         cap_data = 16'd0;
         cap_err  = 1'b1;
      end
   end

   assign rsp_take  = id ? rsp1_ready : rsp0_ready;
   assign busy      = (state != IDLE);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last       <= 1'b1;
         id         <= 1'b0;
         cnt        <= '0;
         alu_a      <= 16'd0;
         alu_b      <= 16'd0;
         alu_ctrl   <= 5'd0;
         rsp0_valid <= 1'b0;
         rsp0_data  <= 16'd0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= 16'd0;
         rsp1_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_a    <= sel_a;
                  alu_b    <= sel_b;
                  alu_ctrl <= sel_op;
                  id       <= grant;
                  cnt      <= is_divmod(sel_op) ? CW'(DIV_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  if (id) begin
                     rsp1_valid <= 1'b1;
                     rsp1_data  <= cap_data;
                     rsp1_err   <= cap_err;
                  end else begin
                     rsp0_valid <= 1'b1;
                     rsp0_data  <= cap_data;
                     rsp0_err   <= cap_err;
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_take) begin
                  if (id) rsp1_valid <= 1'b0;
                  else    rsp0_valid <= 1'b0;
                  last  <= id;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu16_arbiter.sv
// Self-checking bench for alu16_arbiter: directed scenarios plus randomized ops
// checked against a transaction-level model of latency, arbitration order and results.
module tb_alu16_arbiter;

   localparam int EXEC_C = 1;
   localparam int DIV_C  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [4:0]  req0_op, req1_op;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [15:0] rsp0_data, rsp1_data;
   logic        rsp0_err, rsp1_err;
   logic [15:0] alu_a, alu_b, alu_result;
   logic [4:0]  alu_ctrl;
   logic        busy;
   logic [1:0]  fsm_state;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   alu16_arbiter #(.EXEC_CYCLES(EXEC_C), .DIV_CYCLES(DIV_C)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
      .busy(busy), .fsm_state(fsm_state)
   );

   // Stand-in ALU; junk on divide-by-zero and illegal codes so the arbiter must mask it.
   function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         5'd0:    return a + b;
         5'd1:    return a - b;
         5'd2:    return a & b;
         5'd3:    return a | b;
         5'd4:    return a ^ b;
         5'd5:    return a * b;
         5'd7:    return (b == 0) ? 16'hFFFF : a / b;
         5'd8:    return a << b[3:0];
         5'd9:    return (b == 0) ? 16'hDEAD : a % b;
         5'd10:   return a >> b[3:0];
         default: return ~(a + b) | 16'h0001;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

   function automatic logic ref_err(input logic [4:0] op, input logic [15:0] b);
      int o = int'(op);
      return (o == 6) || (o == 11) || (o >= 18) || (((o == 7) || (o == 9)) && b == 0);
   endfunction

   function automatic logic [15:0] ref_data(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
      return ref_err(op, b) ? 16'd0 : alu_fn(op, a, b);
   endfunction

   function automatic int ref_lat(input logic [4:0] op);
      return ((op == 5'd7) || (op == 5'd9)) ? DIV_C + 1 : EXEC_C + 1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_req(input int p, input logic v, input logic [4:0] op,
                          input logic [15:0] a, input logic [15:0] b);
      if (p == 0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      set_req(0, 1'b0, 5'd0, 16'd0, 16'd0);
      set_req(1, 1'b0, 5'd0, 16'd0, 16'd0);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Present a request at a falling edge, report ready, pass the rising edge, drop valid.
   task automatic issue(input int p, input logic [4:0] op, input logic [15:0] a,
                        input logic [15:0] b, output logic got);
      set_req(p, 1'b1, op, a, b);
      #1;
      got = (p == 0) ? req0_ready : req1_ready;
      @(posedge clk);
      @(negedge clk);
      set_req(p, 1'b0, 5'd0, 16'd0, 16'd0);
   endtask

   // Called at the falling edge of cycle T+1; lat is cycles after the handshake cycle T.
   task automatic wait_rsp(input int p, output int lat, output logic [15:0] d, output logic e);
      lat = 1;
      while (((p == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 40) lat = -1;
      d = (p == 0) ? rsp0_data : rsp1_data;
      e = (p == 0) ? rsp0_err : rsp1_err;
   endtask

   task automatic release_rsp(input int p);
      if (p == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      total++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_err, rsp1_err,
           alu_a, alu_b, alu_ctrl, busy} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got nonzero output(s) alu_a=%h alu_b=%h ctrl=%h busy=%b rsp_v=%b%b expected all 0",
                  alu_a, alu_b, alu_ctrl, busy, rsp0_valid, rsp1_valid);
      end
   endtask

   task automatic test_add();
      logic got, e; logic [15:0] d; int lat;
      issue(0, 5'd0, 16'h0003, 16'h0004, got);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL add_ready: got %b expected 1", got); end
      total++; if ({alu_ctrl, alu_a, alu_b, busy} !== {5'd0, 16'h0003, 16'h0004, 1'b1}) begin
         bad++; $display("FAIL add_alu_regs: got ctrl=%h a=%h b=%h busy=%b expected 00/0003/0004/1", alu_ctrl, alu_a, alu_b, busy);
      end
      wait_rsp(0, lat, d, e);
      total++; if (lat !== 2) begin bad++; $display("FAIL add_latency: got %0d expected 2", lat); end
      total++; if ({d, e} !== {16'h0007, 1'b0}) begin bad++; $display("FAIL add_data: got %h err=%b expected 0007 err=0", d, e); end
      release_rsp(0);
      total++; if ({rsp0_valid, busy} !== 2'b00) begin bad++; $display("FAIL add_release: got valid=%b busy=%b expected 0 0", rsp0_valid, busy); end
      repeat (3) @(negedge clk);
      total++; if ({alu_ctrl, alu_a, alu_b} !== {5'd0, 16'h0003, 16'h0004}) begin
         bad++; $display("FAIL alu_hold_idle: got ctrl=%h a=%h b=%h expected 00/0003/0004", alu_ctrl, alu_a, alu_b);
      end
   endtask

   task automatic test_divmod();
      logic got, e; logic [15:0] d; int lat;
      issue(1, 5'b00111, 16'd100, 16'd7, got);
      wait_rsp(1, lat, d, e);
      total++; if (lat !== DIV_C + 1) begin bad++; $display("FAIL div_latency: got %0d expected %0d", lat, DIV_C + 1); end
      total++; if ({d, e} !== {16'd14, 1'b0}) begin bad++; $display("FAIL div_data: got %0d err=%b expected 14 err=0", d, e); end
      total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL div_other_port: got rsp0_valid=%b expected 0", rsp0_valid); end
      release_rsp(1);
      issue(1, 5'b01001, 16'd100, 16'd7, got);
      wait_rsp(1, lat, d, e);
      total++; if (lat !== DIV_C + 1) begin bad++; $display("FAIL mod_latency: got %0d expected %0d", lat, DIV_C + 1); end
      total++; if ({d, e} !== {16'd2, 1'b0}) begin bad++; $display("FAIL mod_data: got %0d err=%b expected 2 err=0", d, e); end
      release_rsp(1);
   endtask

   task automatic test_errors();
      logic [4:0] ops [6] = '{5'b00111, 5'b01001, 5'b00110, 5'b01011, 5'b10010, 5'b11111};
      logic got, e; logic [15:0] d; int lat;
      for (int i = 0; i < 6; i++) begin
         issue(0, ops[i], 16'h1234, (i < 2) ? 16'd0 : 16'h0005, got);
         wait_rsp(0, lat, d, e);
         total++;
         if ({d, e} !== {16'd0, 1'b1} || lat !== ref_lat(ops[i])) begin
            bad++; $display("FAIL err_op_%0d: got data=%h err=%b lat=%0d expected data=0000 err=1 lat=%0d",
                            ops[i], d, e, lat, ref_lat(ops[i]));
         end
         release_rsp(0);
      end
   endtask

   task automatic test_random();
      logic got, e; logic [15:0] d, a, b; logic [4:0] op; int lat, p;
      for (int i = 0; i < 30; i++) begin
         p  = $urandom_range(0, 1);
         op = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 5'd7 : 5'd9) : 5'($urandom_range(0, 31));
         a  = 16'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         exp_q.push_back(ref_data(op, a, b));
         issue(p, op, a, b, got);
         wait_rsp(p, lat, d, e);
         total++;
         if (got !== 1'b1 || lat !== ref_lat(op) || d !== exp_q[0] || e !== ref_err(op, b)) begin
            bad++; $display("FAIL rand_%0d port%0d op=%0d a=%h b=%h: got rdy=%b lat=%0d data=%h err=%b expected rdy=1 lat=%0d data=%h err=%b",
                            i, p, op, a, b, got, lat, d, e, ref_lat(op), exp_q[0], ref_err(op, b));
         end
         void'(exp_q.pop_front());
         release_rsp(p);
      end
   endtask

   task automatic test_hold();
      logic got, e; logic [15:0] d, d1; int lat;
      issue(0, 5'd1, 16'h0010, 16'h0001, got);
      wait_rsp(0, lat, d, e);
      set_req(1, 1'b1, 5'd4, 16'hF0F0, 16'h0FF0);
      #1;
      for (int i = 0; i < 10; i++) begin
         total++;
         if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h000F || req1_ready !== 1'b0) begin
            bad++; $display("FAIL hold_cycle_%0d: got valid=%b data=%h ready1=%b expected 1 000F 0", i, rsp0_valid, rsp0_data, req1_ready);
         end
         @(negedge clk);
         #1;
      end
      rsp0_ready = 1'b1;
      #1;
      total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL hold_release_cycle: got ready1=%b expected 0", req1_ready); end
      @(posedge clk);
      @(negedge clk);
      rsp0_ready = 1'b0;
      #1;
      total++; if ({rsp0_valid, req1_ready} !== 2'b01) begin
         bad++; $display("FAIL hold_next_accept: got valid0=%b ready1=%b expected 0 1", rsp0_valid, req1_ready);
      end
      @(posedge clk);
      @(negedge clk);
      set_req(1, 1'b0, 5'd0, 16'd0, 16'd0);
      wait_rsp(1, lat, d1, e);
      total++; if ({d1, e} !== {16'hFF00, 1'b0} || lat !== 2) begin
         bad++; $display("FAIL hold_req1_result: got data=%h err=%b lat=%0d expected FF00 0 2", d1, e, lat);
      end
      release_rsp(1);
   endtask

   task automatic test_alternation();
      logic [4:0] r_op [2]; logic [15:0] r_a [2]; logic [15:0] r_b [2];
      logic e; logic [15:0] d; int lat, win, mdl_last;
      do_reset();
      mdl_last = 1;
      for (int p = 0; p < 2; p++) begin
         r_op[p] = 5'($urandom_range(0, 5)); r_a[p] = 16'($urandom); r_b[p] = 16'($urandom);
         set_req(p, 1'b1, r_op[p], r_a[p], r_b[p]);
      end
      for (int rnd = 0; rnd < 4; rnd++) begin
         win = 1 - mdl_last;
         #1;
         total++;
         if ({req1_ready, req0_ready} !== ((win == 1) ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL alt_round_%0d: got ready1/0=%b%b expected port %0d", rnd, req1_ready, req0_ready, win);
         end
         @(posedge clk);
         @(negedge clk);
         exp_q.push_back(ref_data(r_op[win], r_a[win], r_b[win]));
         r_op[win] = 5'($urandom_range(0, 5)); r_a[win] = 16'($urandom); r_b[win] = 16'($urandom);
         set_req(win, 1'b1, r_op[win], r_a[win], r_b[win]);
         wait_rsp(win, lat, d, e);
         total++;
         if (d !== exp_q[0] || e !== 1'b0 || lat !== EXEC_C + 1) begin
            bad++; $display("FAIL alt_result_%0d: got data=%h err=%b lat=%0d expected data=%h err=0 lat=%0d", rnd, d, e, lat, exp_q[0], EXEC_C + 1);
         end
         void'(exp_q.pop_front());
         release_rsp(win);
         mdl_last = win;
      end
      set_req(0, 1'b0, 5'd0, 16'd0, 16'd0);
      set_req(1, 1'b0, 5'd0, 16'd0, 16'd0);
   endtask

   task automatic test_reset_mid();
      logic got;
      issue(0, 5'b00111, 16'd1000, 16'd3, got);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_err, rsp1_err, alu_a, alu_b, alu_ctrl, busy} !== '0) begin
         bad++; $display("FAIL midrst_outputs: got busy=%b alu_a=%h alu_b=%h ctrl=%h rsp_v=%b%b expected all 0",
                         busy, alu_a, alu_b, alu_ctrl, rsp0_valid, rsp1_valid);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            bad++; $display("FAIL midrst_no_rsp_%0d: got rsp_v=%b%b expected 00", i, rsp0_valid, rsp1_valid);
         end
         @(negedge clk);
      end
      set_req(0, 1'b1, 5'd0, 16'd1, 16'd1);
      set_req(1, 1'b1, 5'd0, 16'd2, 16'd2);
      #1;
      total++; if ({req1_ready, req0_ready} !== 2'b01) begin
         bad++; $display("FAIL midrst_first_grant: got ready1/0=%b%b expected 01", req1_ready, req0_ready);
      end
      set_req(0, 1'b0, 5'd0, 16'd0, 16'd0);
      set_req(1, 1'b0, 5'd0, 16'd0, 16'd0);
   endtask

   initial begin
      rst = 1'b1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      set_req(0, 1'b0, 5'd0, 16'd0, 16'd0);
      set_req(1, 1'b0, 5'd0, 16'd0, 16'd0);
      test_reset();
      test_add();
      test_divmod();
      test_errors();
      test_random();
      test_hold();
      test_alternation();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
